// File: rtl/er_scheduler.sv
// Frame-synchronised launcher for the Earthrise drawing engine: optional canvas
// clear, then draw, with repeat-every-frame mode and a per-pass watchdog.
module er_scheduler #(
  parameter int unsigned            ADDRW      = 16,
  parameter int unsigned            TOW        = 24,
  parameter logic [TOW-1:0]         TIMEOUT    = 24'hFFFFFF,
  parameter bit                     AUTO_START = 1'b1,
  parameter logic [ADDRW-1:0]       AUTO_ADDR  = '0
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             frame_start,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic             cmd_clear,
  input  logic             cmd_repeat,
  input  logic             cmd_stop,
  output logic             clr_start,
  input  logic             clr_done,
  output logic             er_start,
  output logic [ADDRW-1:0] er_addr,
  input  logic             er_done,
  output logic             busy,
  output logic             error,
  output logic             frame_miss
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_FRAME,
    S_CLEAR,
    S_DRAW
  } state_e;

  localparam state_e RST_STATE = AUTO_START ? S_LAUNCH : S_IDLE;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic             clear_q, clear_d;
  logic             repeat_q, repeat_d;
  logic             error_q, error_d;
  logic [TOW-1:0]   cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             er_start_q, er_start_d;
  logic             clr_start_q, clr_start_d;
  logic             frame_miss_q, frame_miss_d;
  logic             timeout;

  assign timeout = (cnt_q == TIMEOUT);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // below can leave one unassigned and infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    clear_d      = clear_q;
    repeat_d     = repeat_q & ~cmd_stop;
    error_d      = error_q;
    er_start_d   = 1'b0;
    clr_start_d  = 1'b0;
    frame_miss_d = 1'b0;

    unique case (state_q)
      S_LAUNCH: begin
        addr_d     = AUTO_ADDR;
        clear_d    = 1'b0;
        repeat_d   = 1'b0;
        er_start_d = 1'b1;
        state_d    = S_DRAW;
      end
      S_IDLE: begin
        // A frame_start coinciding with the transfer is simply not looked at here.
        if (cmd_valid && cmd_ready_q) begin
          addr_d   = cmd_addr;
          clear_d  = cmd_clear;
          repeat_d = cmd_repeat & ~cmd_stop;
          error_d  = 1'b0;
          state_d  = S_WAIT_FRAME;
        end
      end
      S_WAIT_FRAME: begin
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          if (clear_q) begin
            clr_start_d = 1'b1;
            state_d     = S_CLEAR;
          end else begin
            er_start_d = 1'b1;
            state_d    = S_DRAW;
          end
        end
      end
      S_CLEAR: begin
        frame_miss_d = frame_start;
        if (clr_done) begin
          er_start_d = 1'b1;
          state_d    = S_DRAW;
        end else if (timeout) begin
          error_d  = 1'b1;
          repeat_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_DRAW: begin
        frame_miss_d = frame_start;
        if (er_done) begin
          state_d = repeat_d ? S_WAIT_FRAME : S_IDLE;
        end else if (timeout) begin
          error_d  = 1'b1;
          repeat_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog restarts on every state change, so CLEAR->DRAW gets a fresh budget.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_CLEAR || state_q == S_DRAW) && cnt_q != '1) begin
      cnt_d = cnt_q + TOW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    if (rst_sys) begin
      state_q      <= RST_STATE;
      addr_q       <= '0;
      clear_q      <= 1'b0;
      repeat_q     <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      er_start_q   <= 1'b0;
      clr_start_q  <= 1'b0;
      frame_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      clear_q      <= clear_d;
      repeat_q     <= repeat_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      er_start_q   <= er_start_d;
      clr_start_q  <= clr_start_d;
      frame_miss_q <= frame_miss_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign er_start   = er_start_q;
  assign clr_start  = clr_start_q;
  assign frame_miss = frame_miss_q;
  assign er_addr    = addr_q;

endmodule

// File: tb/tb_er_scheduler.sv
// Scoreboard bench for er_scheduler: stimulus queues expected pulses with their
// cycle numbers, a negedge monitor pops and compares them as the DUT emits pulses.
module tb_er_scheduler;

  localparam int K_ER   = 0;
  localparam int K_CLR  = 1;
  localparam int K_MISS = 2;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          cyc;
  } ev_t;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        frame_start = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic        cmd_clear = 1'b0;
  logic        cmd_repeat = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        clr_done = 1'b0;
  logic        er_done = 1'b0;
  logic        cmd_ready, clr_start, er_start, busy, error, frame_miss;
  logic [15:0] er_addr;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];

  er_scheduler #(
    .ADDRW(16), .TOW(24), .TIMEOUT(24'd100),
    .AUTO_START(1'b1), .AUTO_ADDR(16'h0040)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .frame_start(frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_clear(cmd_clear), .cmd_repeat(cmd_repeat), .cmd_stop(cmd_stop),
    .clr_start(clr_start), .clr_done(clr_done), .er_start(er_start),
    .er_addr(er_addr), .er_done(er_done), .busy(busy), .error(error),
    .frame_miss(frame_miss)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic match(input int kind);
    ev_t e;
    check("ev_pending", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_addr", er_addr, e.addr);
      check("ev_cyc", cyc, e.cyc);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk_sys) begin
    if (er_start === 1'b1)   match(K_ER);
    if (clr_start === 1'b1)  match(K_CLR);
    if (frame_miss === 1'b1) match(K_MISS);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Inputs driven now are sampled at the next edge; the pulse shows one cycle later.
  task automatic expect_ev(input int kind, input logic [15:0] addr);
    exp_q.push_back('{kind, addr, cyc + 1});
  endtask

  task automatic send_cmd(input logic [15:0] addr, input logic clr, input logic rpt,
                          input logic fs);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_clear = clr; cmd_repeat = rpt;
    frame_start = fs;
    tick();
    cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_repeat = 1'b0; frame_start = 1'b0;
  endtask

  task automatic frame(input int kind, input logic [15:0] addr);
    frame_start = 1'b1;
    if (kind >= 0) expect_ev(kind, addr);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pulse_er_done();
    er_done = 1'b1; tick(); er_done = 1'b0;
  endtask

  task automatic pulse_clr_done();
    clr_done = 1'b1; tick(); clr_done = 1'b0;
  endtask

  task automatic check_levels(input string tag, input logic rdy, input logic bsy,
                              input logic err);
    check({tag, "_cmd_ready"}, cmd_ready, rdy);
    check({tag, "_busy"}, busy, bsy);
    check({tag, "_error"}, error, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_levels(tag, 1'b0, 1'b0, 1'b0);
    check({tag, "_er_start"}, er_start, 0);
    check({tag, "_clr_start"}, clr_start, 0);
    check({tag, "_frame_miss"}, frame_miss, 0);
    check({tag, "_er_addr"}, er_addr, 0);
  endtask

  initial begin
    // Reset values, then auto launch in the second cycle after release.
    tick(3);
    check_reset_outputs("rst");
    rst_sys = 1'b0;
    expect_ev(K_ER, 16'h0040);
    tick(4);
    check("auto_er_addr", er_addr, 16'h0040);
    check("auto_busy", busy, 1);
    pulse_er_done();
    check_levels("auto_idle", 1'b1, 1'b0, 1'b0);

    // Clear then draw; a stray er_done during CLEAR is ignored.
    send_cmd(16'h0123, 1'b1, 1'b0, 1'b0);
    check_levels("cd_wait", 1'b0, 1'b1, 1'b0);
    tick(2);
    frame(K_CLR, 16'h0123);
    pulse_er_done();
    check("cd_stray_done_busy", busy, 1);
    tick(2);
    clr_done = 1'b1;
    expect_ev(K_ER, 16'h0123);
    tick();
    clr_done = 1'b0;
    tick(2);
    check("cd_draw_addr", er_addr, 16'h0123);
    pulse_er_done();
    check_levels("cd_idle", 1'b1, 1'b0, 1'b0);

    // Repeat for three frames, a command during DRAW is ignored, stop in WAIT_FRAME.
    send_cmd(16'h0200, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(2);
      frame(K_ER, 16'h0200);
      if (i == 0) begin
        cmd_valid = 1'b1; cmd_addr = 16'hBEEF; tick(); cmd_valid = 1'b0;
      end
      tick(2);
      pulse_er_done();
      check("rep_wait_busy", busy, 1);
    end
    tick(2);
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    check_levels("stop_idle", 1'b1, 1'b0, 1'b0);
    frame(-1, 16'h0000);
    tick(2);
    check("stop_no_relaunch_busy", busy, 0);

    // frame_start in the transfer cycle is ignored; frame_start in DRAW is a miss.
    send_cmd(16'h0300, 1'b0, 1'b0, 1'b1);
    tick(3);
    check("same_cycle_still_waiting", busy, 1);
    frame(K_ER, 16'h0300);
    tick();
    frame(K_MISS, 16'h0300);
    check_levels("miss_no_change", 1'b0, 1'b1, 1'b0);
    pulse_er_done();
    check_levels("miss_idle", 1'b1, 1'b0, 1'b0);

    // Watchdog fires on the 101st DRAW cycle (count 100); a new command clears it.
    send_cmd(16'h0400, 1'b0, 1'b0, 1'b0);
    frame(K_ER, 16'h0400);
    tick(100);
    check_levels("to_edge", 1'b0, 1'b1, 1'b0);
    tick();
    check_levels("to_fired", 1'b1, 1'b0, 1'b1);
    send_cmd(16'h0500, 1'b0, 1'b0, 1'b0);
    check("to_cleared_error", error, 0);
    frame(K_ER, 16'h0500);
    tick(100);
    pulse_er_done();
    check_levels("to_done_wins", 1'b1, 1'b0, 1'b0);

    // One-cycle reset mid-CLEAR; clr_done afterwards never becomes a draw of 0600.
    send_cmd(16'h0600, 1'b1, 1'b0, 1'b0);
    frame(K_CLR, 16'h0600);
    tick(2);
    rst_sys = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    rst_sys = 1'b0;
    clr_done = 1'b1;
    expect_ev(K_ER, 16'h0040);
    tick();
    clr_done = 1'b0;
    tick();
    pulse_clr_done();
    tick(2);
    pulse_er_done();
    check_levels("post_rst_idle", 1'b1, 1'b0, 1'b0);

    tick(3);
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
